// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl
// Sequencer for a row x col array of mac_tile processing elements.
// On an accepted start it performs these steps in order:
//   1. Clears the array.
//   2. Streams col weights in under the kernel-load instruction.
//   3. Waits for the weights to settle.
//   4. Streams len activation vectors in under the execute instruction.
//   5. Waits for partial sums to drain, then pulses done.
//
// Ports
//   clk          : single clock
//   reset        : synchronous, active-high reset
//   start        : operation request, only honoured in IDLE
//   len          : number of activation vectors (latched on accepted start)
//   w_base       : weight base address (latched on accepted start)
//   x_base       : activation base address (latched on accepted start)
//   rd_en        : SRAM read enable
//   rd_addr      : SRAM read address (holds its last value when rd_en is low)
//   inst_w       : west-edge instruction, [1] execute, [0] kernel load
//   array_reset  : reset to all tiles, re-arms their weight latch
//   busy         : high in every state except IDLE
//   done         : one-cycle completion pulse
//   perf_cycles  : busy-cycle counter, only present with MAC_CTRL_PERF_EN
//
// Optional feature macro: MAC_CTRL_PERF_EN adds the perf_cycles output.
//
// All outputs are registered. Each output register is loaded from a decode
// of the next state, so the outputs line up with the state register.

module mac_array_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  output logic [1:0]         inst_w,
  output logic               array_reset,
  output logic               busy,
  output logic               done
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  // The counter must cover the longest phase.
  // The drain phase is always at least as long as the gap phase.
  // Execute can last up to 2^len_bw - 1 cycles.
  localparam int GAP_LEN   = col + 1;
  localparam int DRAIN_LEN = row + col + 1;
  localparam int EXEC_MAX  = (1 << len_bw) - 1;
  localparam int CNT_MAX0  = (GAP_LEN > DRAIN_LEN) ? GAP_LEN : DRAIN_LEN;
  localparam int CNT_MAX   = (CNT_MAX0 > EXEC_MAX) ? CNT_MAX0 : EXEC_MAX;
  localparam int CNT_BW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, GAP, EXEC, DRAIN, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic [len_bw-1:0]   len_q, len_d;
  logic [addr_bw-1:0]  w_base_q, w_base_d;
  logic [addr_bw-1:0]  x_base_q, x_base_d;
  logic                rd_en_q, rd_en_d;
  logic [addr_bw-1:0]  rd_addr_q, rd_addr_d;
  logic [1:0]          inst_w_q, inst_w_d;
  logic                array_reset_q, array_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic.
  // cnt counts cycles spent in the current phase and restarts at zero on
  // every phase change.
  // With len == 0 there is nothing to execute, so GAP goes straight to DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          w_base_d = w_base;
          x_base_d = x_base;
          cnt_d    = '0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (cnt_q == CNT_BW'(col - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_BW'(col)) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? DONE : EXEC;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      EXEC: begin
        if (cnt_q == CNT_BW'(len_q) - CNT_BW'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_BW'(row + col)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, taken from the next state so the registered outputs
  // coincide with the state they describe.
  // The read address advances with the phase counter and otherwise holds.
  // inst_w re-times this cycle's read type by one cycle to match the SRAM
  // read latency. Only one read type is active at a time, so the two
  // instruction bits are never set together.
  always_comb begin
    rd_en_d       = (state_d == LOAD) || (state_d == EXEC);
    rd_addr_d     = rd_addr_q;
    if (state_d == LOAD) begin
      rd_addr_d = w_base_d + addr_bw'(cnt_d);
    end else if (state_d == EXEC) begin
      rd_addr_d = x_base_d + addr_bw'(cnt_d);
    end
    inst_w_d      = {rd_en_q && (state_q == EXEC), rd_en_q && (state_q == LOAD)};
    array_reset_d = (state_d == CLEAR);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      w_base_q      <= '0;
      x_base_q      <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      inst_w_q      <= 2'b00;
      array_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      w_base_q      <= w_base_d;
      x_base_q      <= x_base_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      inst_w_q      <= inst_w_d;
      array_reset_q <= array_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign inst_w      = inst_w_q;
  assign array_reset = array_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef MAC_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;

  // Counts the cycles for which busy is high.
  // The count restarts on an accepted start and holds while idle.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    if (state_q == IDLE && start) begin
      perf_cycles_d = '0;
    end else if (busy_q) begin
      perf_cycles_d = perf_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Testbench for mac_array_ctrl.
//
// The reference model predicts each operation's timeline directly from the
// phase lengths: clear 1, load col, gap col+1, execute len, drain row+col+1,
// done 1.
// Expected reads, instructions and done pulses go into queues. A monitor on
// the falling clock edge pops and compares them whenever the DUT presents
// one of those outputs.
module tb_mac_array_ctrl;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int ADDR_BW = 11;
  localparam int LEN_BW  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_BW-1:0]  len;
  logic [ADDR_BW-1:0] w_base;
  logic [ADDR_BW-1:0] x_base;
  logic               rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic [1:0]         inst_w;
  logic               array_reset;
  logic               busy;
  logic               done;
`ifdef MAC_CTRL_PERF_EN
  logic [31:0]        perf_cycles;
`endif

  mac_array_ctrl #(
    .row(ROW), .col(COL), .addr_bw(ADDR_BW), .len_bw(LEN_BW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(len),
    .w_base(w_base),
    .x_base(x_base),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .inst_w(inst_w),
    .array_reset(array_reset),
    .busy(busy),
    .done(done)
`ifdef MAC_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [ADDR_BW-1:0] addr;
  } rd_exp_t;

  typedef struct {
    int       cyc;
    logic [1:0] val;
  } inst_exp_t;

  rd_exp_t   rd_q[$];
  inst_exp_t inst_q[$];
  int        done_q[$];

  int cyc      = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;
  int clr_cyc  = -1;
  int done_cnt = 0;
  int n_vec    = 0;
  int n_fail   = 0;

  // Counts rising edges. The monitor uses this count as the cycle index.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor.
  // Checks busy and array_reset every cycle against the modelled timeline,
  // and pops an expectation whenever a read, an instruction or done appears.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      checkOutput("array_reset", 32'(array_reset), 32'(cyc == clr_cyc));
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_read", 32'(rd_addr), 32'hFFFF_FFFF);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          checkOutput("rd_addr", 32'(rd_addr), 32'(e.addr));
          checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (inst_w != 2'b00) begin
        if (inst_q.size() == 0) begin
          checkOutput("unexpected_inst", 32'(inst_w), 32'd0);
        end else begin
          inst_exp_t e;
          e = inst_q.pop_front();
          checkOutput("inst_w", 32'(inst_w), 32'(e.val));
          checkOutput("inst_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(cyc), 32'd0);
        end else begin
          checkOutput("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end
    end
  end

  // Issues a start request and pushes the predicted timeline.
  // Relative cycle r after the accepting edge maps to monitor cycle base + r.
  task automatic startOp(input int l, input logic [ADDR_BW-1:0] w,
                         input logic [ADDR_BW-1:0] x);
    int base;
    int done_rel;
    int exec_rel;
    start  = 1'b1;
    len    = LEN_BW'(l);
    w_base = w;
    x_base = x;
    @(posedge clk);
    #1;
    base     = cyc - 1;
    exec_rel = 2 + COL + (COL + 1);
    done_rel = (l == 0) ? exec_rel : exec_rel + l + (ROW + COL + 1);
    clr_cyc  = base + 1;
    busy_lo  = base + 1;
    busy_hi  = base + done_rel;
    for (int k = 0; k < COL; k++) begin
      rd_q.push_back('{base + 2 + k, w + ADDR_BW'(k)});
      inst_q.push_back('{base + 3 + k, 2'b01});
    end
    for (int k = 0; k < l; k++) begin
      rd_q.push_back('{base + exec_rel + k, x + ADDR_BW'(k)});
      inst_q.push_back('{base + exec_rel + 1 + k, 2'b10});
    end
    done_q.push_back(base + done_rel);
    #1;
    start  = 1'b0;
    len    = LEN_BW'($urandom);
    w_base = ADDR_BW'($urandom);
    x_base = ADDR_BW'($urandom);
  endtask

  // Waits (bounded) for the next done pulse.
  // Returns in the first idle cycle after that pulse.
  task automatic waitDone();
    int target;
    bit seen;
    target = done_cnt + 1;
    seen   = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      if (done_cnt >= target) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int l, input logic [ADDR_BW-1:0] w,
                               input logic [ADDR_BW-1:0] x);
    startOp(l, w, x);
    waitDone();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_inst_w"}, 32'(inst_w), 32'd0);
    checkOutput({tag, "_array_reset"}, 32'(array_reset), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    len    = '0;
    w_base = '0;
    x_base = '0;
    repeat (3) tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] basic run");
    applyStimulus(4, 11'h010, 11'h100);
`ifdef MAC_CTRL_PERF_EN
    checkOutput("perf_after_done", perf_cycles, 32'd40);
    repeat (3) tick();
    checkOutput("perf_hold_idle", perf_cycles, 32'd40);
`endif
    repeat (2) tick();

    $display("[TB] zero length");
    applyStimulus(0, 11'h040, 11'h300);
    tick();

    $display("[TB] start while busy");
    startOp(5, 11'h080, 11'h200);
    repeat (19) tick();
    start  = 1'b1;
    len    = 8'd3;
    w_base = 11'h555;
    x_base = 11'h2AA;
    tick();
    start = 1'b0;
    waitDone();
    tick();

    $display("[TB] mid-operation reset");
    startOp(4, 11'h020, 11'h200);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    rd_q.delete();
    inst_q.delete();
    done_q.delete();
    busy_hi = -1;
    clr_cyc = -1;
    reset   = 1'b0;
    #1;
    checkIdleOutputs("abort");
    repeat (3) tick();
    applyStimulus(2, 11'h0F0, 11'h1F0);
    tick();

    $display("[TB] address wrap");
    applyStimulus(3, 11'h7FC, 11'h7FE);
    tick();

    $display("[TB] random runs");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'($urandom_range(0, 20)), ADDR_BW'($urandom),
                    ADDR_BW'($urandom));
      repeat (int'($urandom_range(0, 3))) tick();
    end

    repeat (5) tick();
    checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    checkOutput("inst_queue_empty", 32'(inst_q.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
